dmem_arbiter: RTL and testbench
===============================

// Module: dmem_arbiter
// PURPOSE
//  Shares the single-port data RAM between the MEM pipeline stage and a loader/debug port (program/data preload, memory dump).
//  Sits between the MEM-stage access signals and the RAM array; issues one access per cycle, routes 1-cycle read data back.
//  Pipeline has priority; loader gets idle cycles, optional locked bursts and an optional anti-starvation slot.
// PARAMETERS
//  AW        10  RAM word-address width (1024 words)
//  LOCK_MAX  8   max consecutive cycles a locked loader burst may hold the RAM
//  MAX_WAIT  16  loader wait cycles before a forced grant (only with DMEM_ARB_STARVE_EN)
// PORTS
//  clk       in   1   clock, rising edge
//  reset     in   1   asynchronous, active-high
//  p_req     in   1   pipeline access (MemRead|MemWrite)
//  p_we      in   1   pipeline write
//  p_addr    in   32  pipeline byte address
//  p_wdata   in   32  pipeline write data
//  p_stall   out  1   pipeline access not taken this cycle; hold request
//  p_rvalid  out  1   pipeline read data valid
//  p_rdata   out  32  pipeline read data
//  l_req     in   1   loader access
//  l_we      in   1   loader write
//  l_lock    in   1   loader requests to keep RAM next cycle (burst)
//  l_addr    in   32  loader byte address
//  l_wdata   in   32  loader write data
//  l_gnt     out  1   loader access taken this cycle
//  l_rvalid  out  1   loader read data valid
//  l_rdata   out  32  loader read data
//  m_en, m_we out 1   RAM enable / write enable
//  m_addr    out  AW  RAM word address = addr[AW+1:2]
//  m_wdata   out  32  RAM write data
//  m_rdata   in   32  RAM read data, registered, 1-cycle latency
// BEHAVIOUR
//  - Grant is combinational from state + requests; m_* driven same cycle. Selected requester's addr/we/wdata muxed to m_*.
//  - Address: bits [1:0] ignored (word access), bits above AW+1 ignored (wraps modulo 2^AW words).
//  - States: IDLE, PIPE (pipeline owned last cycle), LOCK (loader burst in progress). State updates every posedge.
//  - IDLE/PIPE: p_req -> grant pipeline, ->PIPE. Else l_req -> grant loader; -> LOCK if l_lock else IDLE. Else none, ->IDLE.
//  - LOCK: l_req&l_lock and lock_cnt<LOCK_MAX -> grant loader, stay LOCK; p_stall=p_req.
//    Otherwise behave as IDLE this cycle (pipeline first). lock_cnt counts loader grants in LOCK, cleared on exit.
//  - l_req low while in LOCK ends burst immediately (IDLE rules apply that cycle).
//  - p_stall = p_req & ~pipeline_granted. l_gnt = loader_granted. Never both granted; m_en=0 when neither.
//  - Writes: m_we = granted_we; RAM writes at posedge. Reads: rd_owner (2'b: none/P/L) registered at grant;
//    next cycle p_rvalid or l_rvalid pulses 1 cycle; p_rdata/l_rdata = m_rdata when valid, else 0.
//  - Writes produce no rvalid. Back-to-back reads from either side sustain 1 access/cycle.
//  - Reset (async): state IDLE, lock_cnt=0, wait_cnt=0, rd_owner=none; p_rvalid=l_rvalid=0, rdata=0.
//    While reset high m_en=m_we=0, p_stall=0, l_gnt=0. Read in flight at reset is dropped (no rvalid).
//  - Same-cycle p_req and l_req from IDLE: pipeline wins; loader waits (l_gnt=0), must hold request.
// CONFIGURATION
//  DMEM_ARB_STARVE_EN defined: wait_cnt increments each cycle l_req&~l_gnt, clears on l_gnt or ~l_req.
//    When wait_cnt==MAX_WAIT, loader granted that cycle regardless of p_req (p_stall=p_req), lock not entered; wait_cnt->0.
//  Not defined: no wait_cnt; loader can starve indefinitely under continuous p_req.
// TESTING
//  1 Reset: assert reset mid-read -> p_rvalid=0 next cycle, m_en=0 during reset, state IDLE after release.
//  2 Pipeline write 0xDEADBEEF @0x40 then read @0x40 -> m_addr=0x010, p_rvalid 1 cycle later, p_rdata=0xDEADBEEF, p_stall=0.
//  3 p_req & l_req same cycle -> pipeline granted, l_gnt=0; drop p_req -> l_gnt=1 next cycle, l_rvalid following cycle.
//  4 Loader lock burst, l_lock held 12 cycles, p_req raised at 2nd beat -> 8 loader grants, p_stall=1 for them, then pipeline granted.
//  5 Address 0x1004 with AW=10 -> m_addr=0x001 (wrap); p_addr=0x43 -> m_addr=0x010.
//  6 STARVE_EN: continuous p_req, l_req held -> l_gnt=1 on 17th cycle, p_stall=1 that cycle only; without macro l_gnt never.

Source files
------------

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares the single-port data RAM between the MEM stage and a loader/debug port.
// Optional feature: define DMEM_ARB_STARVE_EN to force a loader grant after MAX_WAIT waiting cycles.
module dmem_arbiter #(
  parameter int AW       = 10,
  parameter int LOCK_MAX = 8,
  parameter int MAX_WAIT = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          p_req,
  input  logic          p_we,
  input  logic [31:0]   p_addr,
  input  logic [31:0]   p_wdata,
  output logic          p_stall,
  output logic          p_rvalid,
  output logic [31:0]   p_rdata,
  input  logic          l_req,
  input  logic          l_we,
  input  logic          l_lock,
  input  logic [31:0]   l_addr,
  input  logic [31:0]   l_wdata,
  output logic          l_gnt,
  output logic          l_rvalid,
  output logic [31:0]   l_rdata,
  output logic          m_en,
  output logic          m_we,
  output logic [AW-1:0] m_addr,
  output logic [31:0]   m_wdata,
  input  logic [31:0]   m_rdata
);
  localparam int CW = $clog2(LOCK_MAX + 1);
  localparam int WW = $clog2(MAX_WAIT + 1);
  localparam logic [1:0] RD_NONE = 2'd0, RD_P = 2'd1, RD_L = 2'd2;
  typedef enum logic [1:0] {IDLE, PIPE, LOCK} state_t;
  state_t state, state_nx;
  logic [CW-1:0] lock_cnt;
  logic [1:0] rd_owner;
  logic starve, lock_go, p_gnt;
  logic [31:0] addr;
  logic unused_addr;
`ifdef DMEM_ARB_STARVE_EN
  logic [WW-1:0] wait_cnt;
  assign starve = l_req && wait_cnt == WW'(MAX_WAIT);
  // count cycles the loader has been kept waiting
  always_ff @(posedge clk or posedge reset)
    if (reset) wait_cnt <= '0;
    else wait_cnt <= (l_req && !l_gnt) ? wait_cnt + 1'b1 : '0;
`else
  logic [WW-1:0] unused_wait;
  assign unused_wait = '0;
  assign starve = 1'b0;
`endif
  // grant selection and RAM request mux; PIPE behaves like IDLE, only LOCK changes priority
  always_comb begin
    lock_go = state == LOCK && l_req && l_lock && lock_cnt < CW'(LOCK_MAX);
    l_gnt = !reset && (starve || lock_go || (!p_req && l_req));
    p_gnt = !reset && !starve && !lock_go && p_req;
    state_nx = p_gnt ? PIPE : (l_gnt && l_lock && !starve) ? LOCK : IDLE;
    p_stall = !reset && p_req && !p_gnt;
    addr = p_gnt ? p_addr : l_addr;
    m_en = p_gnt || l_gnt;
    m_we = p_gnt ? p_we : l_gnt && l_we;
    m_addr = addr[AW+1:2];
    m_wdata = p_gnt ? p_wdata : l_wdata;
    unused_addr = ^{addr[31:AW+2], addr[1:0]};
  end
  // state, burst length and read-owner registers
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state <= IDLE;
      lock_cnt <= '0;
      rd_owner <= RD_NONE;
    end else begin
      state <= state_nx;
      lock_cnt <= lock_go ? lock_cnt + 1'b1 : '0;
      rd_owner <= (p_gnt && !p_we) ? RD_P : (l_gnt && !l_we) ? RD_L : RD_NONE;
    end
  assign p_rvalid = rd_owner == RD_P;
  assign l_rvalid = rd_owner == RD_L;
  assign p_rdata = p_rvalid ? m_rdata : '0;
  assign l_rdata = l_rvalid ? m_rdata : '0;
endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed and random checks of dmem_arbiter against a cycle-level behavioural model.
module tb_dmem_arbiter;
  localparam int AW = 10, LOCK_MAX = 8, MAX_WAIT = 16;
`ifdef DMEM_ARB_STARVE_EN
  localparam bit STARVE = 1'b1;
`else
  localparam bit STARVE = 1'b0;
`endif
  logic clk = 1'b0, reset;
  logic p_req, p_we, p_stall, p_rvalid, l_req, l_we, l_lock, l_gnt, l_rvalid, m_en, m_we;
  logic [31:0] p_addr, p_wdata, p_rdata, l_addr, l_wdata, l_rdata, m_wdata, m_rdata;
  logic [AW-1:0] m_addr;
  logic [31:0] ram [0:1023];
  logic [31:0] exp_mem [0:1023];
  bit burst, seen_lg;
  int beats, waited, pend, total = 0, bad = 0;
  logic [31:0] pend_data;

  always #5 clk = ~clk;

  dmem_arbiter #(.AW(AW), .LOCK_MAX(LOCK_MAX), .MAX_WAIT(MAX_WAIT)) dut (
    .clk(clk), .reset(reset),
    .p_req(p_req), .p_we(p_we), .p_addr(p_addr), .p_wdata(p_wdata),
    .p_stall(p_stall), .p_rvalid(p_rvalid), .p_rdata(p_rdata),
    .l_req(l_req), .l_we(l_we), .l_lock(l_lock), .l_addr(l_addr), .l_wdata(l_wdata),
    .l_gnt(l_gnt), .l_rvalid(l_rvalid), .l_rdata(l_rdata),
    .m_en(m_en), .m_we(m_we), .m_addr(m_addr), .m_wdata(m_wdata), .m_rdata(m_rdata)
  );

  // RAM with registered read, 1-cycle latency
  always @(posedge clk)
    if (m_en) begin
      if (m_we) ram[m_addr] <= m_wdata;
      m_rdata <= ram[m_addr];
    end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%h exp=%h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic drv(input bit pr, input bit pw, input logic [31:0] pa, input logic [31:0] pd,
                     input bit lr, input bit lw, input bit ll, input logic [31:0] la, input logic [31:0] ld);
    p_req = pr; p_we = pw; p_addr = pa; p_wdata = pd;
    l_req = lr; l_we = lw; l_lock = ll; l_addr = la; l_wdata = ld;
  endtask

  task automatic model_reset();
    burst = 0; beats = 0; waited = 0; pend = 0; pend_data = '0;
  endtask

  // one clock cycle: predict grants from the arbitration rules, check, then advance the model
  task automatic cycle();
    bit st, go, pg, lg, we;
    int w;
    logic [31:0] a, d;
    #1;
    st = STARVE && l_req && waited == MAX_WAIT;
    go = burst && l_req && l_lock && beats < LOCK_MAX;
    lg = st || go || (!p_req && l_req);
    pg = p_req && !lg;
    a = pg ? p_addr : l_addr;
    d = pg ? p_wdata : l_wdata;
    we = pg ? p_we : l_we;
    w = int'((a >> 2) % 1024);
    seen_lg = l_gnt;
    chk("p_stall", p_stall, p_req && !pg);
    chk("l_gnt", l_gnt, lg);
    chk("m_en", m_en, pg || lg);
    if (pg || lg) begin
      chk("m_we", m_we, we);
      chk("m_addr", m_addr, w);
      if (we) chk("m_wdata", m_wdata, d);
    end
    chk("p_rvalid", p_rvalid, pend == 1);
    chk("p_rdata", p_rdata, pend == 1 ? pend_data : 32'h0);
    chk("l_rvalid", l_rvalid, pend == 2);
    chk("l_rdata", l_rdata, pend == 2 ? pend_data : 32'h0);
    @(posedge clk);
    if ((pg || lg) && !we) begin
      pend = pg ? 1 : 2;
      pend_data = exp_mem[w];
    end else pend = 0;
    if ((pg || lg) && we) exp_mem[w] = d;
    burst = lg && l_lock && !st;
    beats = go ? beats + 1 : 0;
    waited = (l_req && !lg) ? waited + 1 : 0;
    @(negedge clk);
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
  endtask

  initial begin
    int cnt, first;
    logic [31:0] pa, la;
    for (int i = 0; i < 1024; i++) begin
      ram[i] = '0;
      exp_mem[i] = '0;
    end
    model_reset();
    reset = 1'b1;
    drv(1, 1, 32'h40, 32'h1, 1, 1, 1, 32'h80, 32'h2);
    #1;
    chk("rst_m_en", m_en, 0);
    chk("rst_m_we", m_we, 0);
    chk("rst_p_stall", p_stall, 0);
    chk("rst_l_gnt", l_gnt, 0);
    chk("rst_p_rvalid", p_rvalid, 0);
    @(negedge clk);
    reset = 1'b0;
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    // pipeline write then read at 0x40
    drv(1, 1, 32'h40, 32'hDEADBEEF, 0, 0, 0, 0, 0);
    #1;
    chk("t2_waddr", m_addr, 10'h010);
    cycle();
    drv(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t2_rdata", p_rdata, 32'hDEADBEEF);
    cycle();
    // reset asserted while a read is in flight drops the rvalid
    drv(1, 0, 32'h40, 0, 0, 0, 0, 0, 0);
    cycle();
    reset = 1'b1;
    #1;
    chk("t1_p_rvalid", p_rvalid, 0);
    chk("t1_p_rdata", p_rdata, 0);
    chk("t1_m_en", m_en, 0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b0;
    model_reset();
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    // simultaneous requests: pipeline first, loader next
    drv(1, 1, 32'h80, 32'h12345678, 1, 0, 0, 32'h80, 0);
    #1;
    chk("t3_l_gnt0", l_gnt, 0);
    chk("t3_p_stall", p_stall, 0);
    cycle();
    drv(0, 0, 0, 0, 1, 0, 0, 32'h80, 0);
    cycle();
    chk("t3_l_gnt1", seen_lg, 1);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t3_l_rdata", l_rdata, 32'h12345678);
    cycle();
    // locked burst of 12 cycles, pipeline joins at the 2nd beat
    cnt = 0;
    for (int i = 0; i < 12; i++) begin
      drv(i > 0, 0, 32'h40, 0, 1, 0, 1, 32'h100 + 32'(4 * i), 0);
      cycle();
      if (i > 0 && seen_lg) cnt++;
    end
    chk("t4_locked_beats", cnt, LOCK_MAX);
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    // address wrap and byte-offset masking
    drv(1, 0, 32'h43, 0, 0, 0, 0, 0, 0);
    #1;
    chk("t5_p_addr", m_addr, 10'h010);
    cycle();
    drv(0, 0, 0, 0, 1, 0, 0, 32'h1004, 0);
    #1;
    chk("t5_l_addr", m_addr, 10'h001);
    cycle();
    // continuous pipeline traffic against a waiting loader
    do_reset();
    first = 0;
    for (int i = 1; i <= 20; i++) begin
      drv(1, 0, 32'h40, 0, 1, 0, 0, 32'h80, 0);
      cycle();
      if (seen_lg && first == 0) first = i;
    end
    chk("t6_first_lgnt", first, STARVE ? MAX_WAIT + 1 : 0);
    // random traffic with wrapping addresses
    for (int i = 0; i < 400; i++) begin
      pa = ($urandom_range(0, 15) << 2) | ($urandom & 3) | (($urandom & 3) << 12);
      la = ($urandom_range(0, 15) << 2) | ($urandom & 3) | (($urandom & 3) << 12);
      drv($urandom_range(0, 9) < 5, $urandom_range(0, 1) == 1, pa, $urandom,
          $urandom_range(0, 9) < 6, $urandom_range(0, 1) == 1, $urandom_range(0, 9) < 7, la, $urandom);
      cycle();
    end
    drv(0, 0, 0, 0, 0, 0, 0, 0, 0);
    cycle();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
